// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and helpers for scan_decoder.
//   state_t   - FSM states (IDLE, DIRECT, SCAN)
//   DWELL_W   - width of the dwell counter
//   onehot()  - decodes a code to a one-hot (or one-cold) vector of
//               MAX_OUT_W bits; callers keep the low 2**SEL_W bits.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam int DWELL_W   = 16;
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    // A package function cannot depend on the instance's SEL_W, so it works
    // at the widest supported size and the caller slices down.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] code,
                                                    input logic                 active_low);
        logic [MAX_OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// scan_counter: dwell counter plus code counter for the scan sequence.
//   clk, rst_n - clock, async active-low reset
//   clr        - load dwell and code to zero (scan entry / not scanning)
//   step       - advance dwell by one, code on dwell rollover
//   code_nxt   - code to be driven after the coming edge
//   wrap_nxt   - high when code_nxt is the 0 reached by wrapping from OUT_W-1
// Next-state values are exposed so the owner can register its outputs
// from them and keep out/cur_code/wrap aligned with the counter.
module scan_counter
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    output logic [SEL_W-1:0] code_nxt,
    output logic             wrap_nxt
);

    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]   CODE_MAX  = '1;

    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [SEL_W-1:0]   code_q;

    always_comb begin
        dwell_d  = dwell_q;
        code_nxt = code_q;
        wrap_nxt = 1'b0;
        if (clr) begin
            dwell_d  = '0;
            code_nxt = '0;
        end else if (step) begin
            if (dwell_q == DWELL_MAX) begin
                dwell_d  = '0;
                code_nxt = code_q + 1'b1;
                wrap_nxt = (code_q == CODE_MAX);
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            code_q  <= '0;
        end else begin
            dwell_q <= dwell_d;
            code_q  <= code_nxt;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered binary-to-one-hot decoder with direct
// (valid/ready) and autonomous scan modes.
//   clk, rst_n - clock, async active-low reset
//   en         - block enable; low forces IDLE with inactive out
//   mode       - 0 direct, 1 scan
//   in_valid / in_code / in_ready - direct-mode handshake
//   out        - registered one-hot (one-cold if ACTIVE_LOW) select
//   out_valid  - out holds a selected code
//   cur_code   - code currently driven on out
//   wrap       - one-cycle pulse on the first cycle code 0 returns in scan
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    input  logic [SEL_W-1:0]      in_code,
    output logic                  in_ready,
    output logic [2**SEL_W-1:0]   out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      cur_code,
    output logic                  wrap
);

    localparam int             OUT_W = 2 ** SEL_W;
    localparam logic [OUT_W-1:0] INACT = (ACTIVE_LOW != 0) ? '1 : '0;

    function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] c);
        logic [MAX_OUT_W-1:0] full;
        full = onehot(MAX_SEL_W'(c), ACTIVE_LOW != 0);
        return full[OUT_W-1:0];
    endfunction

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_d;
    logic               vld_d, wrap_d;
    logic [SEL_W-1:0]   code_d;
    logic               scanning;
    logic [SEL_W-1:0]   sc_code_nxt;
    logic               sc_wrap_nxt;

    assign in_ready = (state_q == DIRECT) && en && !mode;

    // Counter only runs while we stay in SCAN; anything else holds it at
    // zero, so scan entry (from IDLE or DIRECT) always restarts at code 0
    // with a full dwell and no wrap pulse.
    assign scanning = (state_q == SCAN) && en && mode;

    scan_counter #(
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!scanning),
        .step     (scanning),
        .code_nxt (sc_code_nxt),
        .wrap_nxt (sc_wrap_nxt)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out;
        vld_d   = out_valid;
        code_d  = cur_code;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            out_d   = INACT;
            vld_d   = 1'b0;
        end else if (mode) begin
            state_d = SCAN;
            out_d   = dec(sc_code_nxt);
            vld_d   = 1'b1;
            code_d  = sc_code_nxt;
            wrap_d  = sc_wrap_nxt;
        end else begin
            // Entering DIRECT from SCAN keeps the last scanned select until
            // the first accept; from IDLE out stays inactive.
            state_d = DIRECT;
            if (in_valid && in_ready) begin
                out_d  = dec(in_code);
                vld_d  = 1'b1;
                code_d = in_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out       <= INACT;
            out_valid <= 1'b0;
            cur_code  <= '0;
            wrap      <= 1'b0;
        end else begin
            state_q   <= state_d;
            out       <= out_d;
            out_valid <= vld_d;
            cur_code  <= code_d;
            wrap      <= wrap_d;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
module tb_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       in_valid;
    logic [2:0] in_code;

    // default instance: SEL_W=3, DWELL=4, active high
    logic       rdy_a;
    logic [7:0] out_a;
    logic       vld_a;
    logic [2:0] code_a;
    logic       wrap_a;

    // active-low instance
    logic       rdy_l;
    logic [7:0] out_l;
    logic       vld_l;
    logic [2:0] code_l;
    logic       wrap_l;

    // SEL_W=2, DWELL=1 instance
    logic       rdy_s;
    logic [3:0] out_s;
    logic       vld_s;
    logic [1:0] code_s;
    logic       wrap_s;

    int total = 0;
    int bad   = 0;

    scan_decoder #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_code(in_code), .in_ready(rdy_a), .out(out_a), .out_valid(vld_a),
        .cur_code(code_a), .wrap(wrap_a)
    );

    scan_decoder #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_code(in_code), .in_ready(rdy_l), .out(out_l), .out_valid(vld_l),
        .cur_code(code_l), .wrap(wrap_l)
    );

    scan_decoder #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_code(in_code[1:0]), .in_ready(rdy_s), .out(out_s), .out_valid(vld_s),
        .cur_code(code_s), .wrap(wrap_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_code = 3'd0;
        #12;
        total++; if (out_a !== 8'h00) begin bad++; $display("FAIL reset_out got=%h exp=00", out_a); end
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", vld_a); end
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", rdy_a); end
        total++; if (code_a !== 3'd0) begin bad++; $display("FAIL reset_cur_code got=%0d exp=0", code_a); end
        total++; if (wrap_a !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", wrap_a); end
        total++; if (out_l !== 8'hFF) begin bad++; $display("FAIL reset_out_al got=%h exp=ff", out_l); end
        total++; if (out_s !== 4'h0) begin bad++; $display("FAIL reset_out_s got=%h exp=0", out_s); end
        rst_n = 1'b1;
        step();
        total++; if (out_a !== 8'h00) begin bad++; $display("FAIL idle_out got=%h exp=00", out_a); end
    endtask

    task automatic test_direct();
        logic [2:0] codes [4];
        logic [7:0] exp   [4];
        codes = '{3'd2, 3'd6, 3'd5, 3'd5};
        exp   = '{8'h04, 8'h40, 8'h20, 8'h20};
        en = 1'b1; mode = 1'b0; in_valid = 1'b0;
        step();
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL direct_ready got=%b exp=1", rdy_a); end
        total++; if (out_a !== 8'h00) begin bad++; $display("FAIL direct_entry_out got=%h exp=00", out_a); end
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL direct_entry_valid got=%b exp=0", vld_a); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_code = codes[i];
            step();
            total++; if (out_a !== exp[i]) begin bad++; $display("FAIL direct_out[%0d] got=%h exp=%h", i, out_a, exp[i]); end
            total++; if (code_a !== codes[i]) begin bad++; $display("FAIL direct_code[%0d] got=%0d exp=%0d", i, code_a, codes[i]); end
            total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL direct_valid[%0d] got=%b exp=1", i, vld_a); end
            total++; if (out_l !== ~exp[i]) begin bad++; $display("FAIL direct_out_al[%0d] got=%h exp=%h", i, out_l, ~exp[i]); end
        end
        in_valid = 1'b0; in_code = 3'd1;
        step();
        step();
        total++; if (out_a !== 8'h20) begin bad++; $display("FAIL direct_hold got=%h exp=20", out_a); end
        total++; if (code_a !== 3'd5) begin bad++; $display("FAIL direct_hold_code got=%0d exp=5", code_a); end
    endtask

    // en drops while in_valid is high: no accept, outputs go inactive
    task automatic test_disable_direct();
        en = 1'b0; in_valid = 1'b1; in_code = 3'd3;
        step();
        total++; if (out_a !== 8'h00) begin bad++; $display("FAIL dis_out got=%h exp=00", out_a); end
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL dis_valid got=%b exp=0", vld_a); end
        total++; if (code_a !== 3'd5) begin bad++; $display("FAIL dis_code_hold got=%0d exp=5", code_a); end
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL dis_ready got=%b exp=0", rdy_a); end
        total++; if (out_l !== 8'hFF) begin bad++; $display("FAIL dis_out_al got=%h exp=ff", out_l); end
        in_valid = 1'b0;
    endtask

    task automatic test_scan();
        int         c1, c2;
        logic [7:0] e1;
        logic [3:0] e2;
        logic       w1, w2;
        en = 1'b0; mode = 1'b1;
        step();
        en = 1'b1;
        for (int i = 0; i <= 33; i++) begin
            step();
            c1 = (i / 4) % 8;
            c2 = i % 4;
            e1 = 8'h01 << c1;
            e2 = 4'h1 << c2;
            w1 = (i == 32);
            w2 = (i != 0) && (c2 == 0);
            total++; if (out_a !== e1) begin bad++; $display("FAIL scan_out[%0d] got=%h exp=%h", i, out_a, e1); end
            total++; if (code_a !== 3'(c1)) begin bad++; $display("FAIL scan_code[%0d] got=%0d exp=%0d", i, code_a, c1); end
            total++; if (wrap_a !== w1) begin bad++; $display("FAIL scan_wrap[%0d] got=%b exp=%b", i, wrap_a, w1); end
            total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL scan_valid[%0d] got=%b exp=1", i, vld_a); end
            total++; if (out_s !== e2) begin bad++; $display("FAIL scan1_out[%0d] got=%h exp=%h", i, out_s, e2); end
            total++; if (wrap_s !== w2) begin bad++; $display("FAIL scan1_wrap[%0d] got=%b exp=%b", i, wrap_s, w2); end
            if (i == 0) begin
                total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL scan_ready got=%b exp=0", rdy_a); end
            end
        end
    endtask

    task automatic test_disable_mid_scan();
        en = 1'b0; mode = 1'b1;
        step();
        en = 1'b1;
        step();                       // code 0, dwell 0
        for (int i = 0; i < 14; i++) step();  // code 3, dwell 2
        total++; if (out_a !== 8'h08) begin bad++; $display("FAIL mid_pre_out got=%h exp=08", out_a); end
        en = 1'b0;
        step();
        total++; if (out_a !== 8'h00) begin bad++; $display("FAIL mid_off_out got=%h exp=00", out_a); end
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL mid_off_valid got=%b exp=0", vld_a); end
        total++; if (code_a !== 3'd3) begin bad++; $display("FAIL mid_off_code got=%0d exp=3", code_a); end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) begin
                total++; if (out_a !== 8'h01) begin bad++; $display("FAIL mid_restart[%0d] got=%h exp=01", i, out_a); end
                total++; if (wrap_a !== 1'b0) begin bad++; $display("FAIL mid_restart_wrap[%0d] got=%b exp=0", i, wrap_a); end
            end else begin
                total++; if (out_a !== 8'h02) begin bad++; $display("FAIL mid_restart_adv got=%h exp=02", out_a); end
            end
        end
    endtask

    // scan currently at code 1 (out 02) from the previous task
    task automatic test_mode_switch();
        mode = 1'b0; in_valid = 1'b0;
        step();
        total++; if (out_a !== 8'h02) begin bad++; $display("FAIL sw_hold_out got=%h exp=02", out_a); end
        total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL sw_hold_valid got=%b exp=1", vld_a); end
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL sw_ready got=%b exp=1", rdy_a); end
        in_valid = 1'b1; in_code = 3'd7;
        step();
        total++; if (out_a !== 8'h80) begin bad++; $display("FAIL sw_accept got=%h exp=80", out_a); end
        mode = 1'b1;
        step();
        total++; if (out_a !== 8'h01) begin bad++; $display("FAIL sw_rescan_out got=%h exp=01", out_a); end
        total++; if (code_a !== 3'd0) begin bad++; $display("FAIL sw_rescan_code got=%0d exp=0", code_a); end
        total++; if (wrap_a !== 1'b0) begin bad++; $display("FAIL sw_rescan_wrap got=%b exp=0", wrap_a); end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        mode = 1'b0;
        step();
        in_valid = 1'b1; in_code = 3'd5;
        step();
        total++; if (out_a !== 8'h20) begin bad++; $display("FAIL ar_pre_out got=%h exp=20", out_a); end
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        total++; if (out_a !== 8'h00) begin bad++; $display("FAIL ar_out got=%h exp=00", out_a); end
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", vld_a); end
        total++; if (code_a !== 3'd0) begin bad++; $display("FAIL ar_code got=%0d exp=0", code_a); end
        total++; if (out_l !== 8'hFF) begin bad++; $display("FAIL ar_out_al got=%h exp=ff", out_l); end
        #2 rst_n = 1'b1;
        #1;
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL ar_ready_idle got=%b exp=0", rdy_a); end
        step();
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL ar_ready_direct got=%b exp=1", rdy_a); end
        total++; if (out_a !== 8'h00) begin bad++; $display("FAIL ar_post_out got=%h exp=00", out_a); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_disable_direct();
        test_scan();
        test_disable_mid_scan();
        test_mode_switch();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
